// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side controller: request capture, programmable wait states, RAM access
// and the memory-mapped keyboard/display registers, with a one-cycle ready pulse.
module lc3_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [15:0]       mem_addr_i,
  input  logic [15:0]       mem_wdata_i,
  output logic [15:0]       mem_rdata_o,
  output logic              mem_ready_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [15:0]       ram_wdata_o,
  input  logic [15:0]       ram_rdata_i,
  input  logic              kb_valid_i,
  input  logic [7:0]        kb_data_i,
  output logic              kb_ready_o,
  output logic              dd_valid_o,
  output logic [7:0]        dd_data_o,
  input  logic              dd_ready_i
);

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] WMAX = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q, dev_q;
  logic [15:0]     addr_q, wdata_q, rsp_q, rdata_q, dev_rd;
  logic            ready_q;
  logic [CW-1:0]   cnt_q;
  logic            kb_full_q, dd_pend_q;
  logic [7:0]      kb_buf_q, dd_data_q;
  logic            stall, acc_done;

  // A DDR write waits in ACCESS while the previous character is still pending.
  assign stall    = dev_q && we_q && (addr_q == DDR) && dd_pend_q;
  assign acc_done = (state_q == S_ACCESS) && !stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (mem_en_i) state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt_q == WMAX) state_d = S_ACCESS;
      S_ACCESS: if (!stall) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_en_o    = (state_q == S_ACCESS) && !dev_q;
    ram_we_o    = (state_q == S_ACCESS) && !dev_q && we_q;
    ram_addr_o  = addr_q[ADDR_W-1:0];
    ram_wdata_o = wdata_q;
    mem_ready_o = ready_q;
    mem_rdata_o = rdata_q;
    kb_ready_o  = !kb_full_q;
    dd_valid_o  = dd_pend_q;
    dd_data_o   = dd_data_q;
  end

  always_comb begin
    dev_rd = '0;
    if (!we_q) begin
      case (addr_q)
        KBSR:    dev_rd = {kb_full_q, 15'b0};
        KBDR:    dev_rd = {8'h00, kb_buf_q};
        DSR:     dev_rd = {!dd_pend_q, 15'b0};
        default: dev_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      dev_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rsp_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      kb_full_q <= 1'b0;
      kb_buf_q  <= '0;
      dd_pend_q <= 1'b0;
      dd_data_q <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      if (state_q == S_IDLE && mem_en_i) begin
        we_q    <= mem_we_i;
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        dev_q   <= (mem_addr_i[15:9] == 7'h7F);
        cnt_q   <= '0;
      end
      if (state_q == S_WAIT) cnt_q <= cnt_q + CW'(1);
      // Device value is frozen at ACCESS so later keyboard traffic cannot alter it.
      if (acc_done && dev_q) rsp_q <= dev_rd;
      if (state_q == S_RESP) begin
        ready_q <= 1'b1;
        rdata_q <= we_q ? 16'h0000 : (dev_q ? rsp_q : ram_rdata_i);
      end
      if (acc_done && dev_q && !we_q && addr_q == KBDR) kb_full_q <= 1'b0;
      if (kb_valid_i && !kb_full_q) begin
        kb_full_q <= 1'b1;
        kb_buf_q  <= kb_data_i;
      end
      if (dd_pend_q && dd_ready_i) dd_pend_q <= 1'b0;
      if (acc_done && dev_q && we_q && addr_q == DDR) begin
        dd_pend_q <= 1'b1;
        dd_data_q <= wdata_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: DUT A (ADDR_W=16, no wait states) and DUT B (ADDR_W=12, 3 wait
// states) against a transaction-level model of memory contents and device registers.
module tb_lc3_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, en, we, kbv, ddr;
  logic [1:0][15:0] addr, wd, ramrd;
  logic [1:0][7:0]  kbd;
  wire  [1:0]       rdy, ram_en, ram_we, kbr, ddv;
  wire  [1:0][15:0] rdata, ramwd;
  wire  [1:0][7:0]  ddd;
  wire  [15:0]      ra_a;
  wire  [11:0]      ra_b;

  lc3_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(0)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .mem_en_i(en[0]), .mem_we_i(we[0]),
    .mem_addr_i(addr[0]), .mem_wdata_i(wd[0]), .mem_rdata_o(rdata[0]),
    .mem_ready_o(rdy[0]), .ram_en_o(ram_en[0]), .ram_we_o(ram_we[0]),
    .ram_addr_o(ra_a), .ram_wdata_o(ramwd[0]), .ram_rdata_i(ramrd[0]),
    .kb_valid_i(kbv[0]), .kb_data_i(kbd[0]), .kb_ready_o(kbr[0]),
    .dd_valid_o(ddv[0]), .dd_data_o(ddd[0]), .dd_ready_i(ddr[0]));

  lc3_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(3)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .mem_en_i(en[1]), .mem_we_i(we[1]),
    .mem_addr_i(addr[1]), .mem_wdata_i(wd[1]), .mem_rdata_o(rdata[1]),
    .mem_ready_o(rdy[1]), .ram_en_o(ram_en[1]), .ram_we_o(ram_we[1]),
    .ram_addr_o(ra_b), .ram_wdata_o(ramwd[1]), .ram_rdata_i(ramrd[1]),
    .kb_valid_i(kbv[1]), .kb_data_i(kbd[1]), .kb_ready_o(kbr[1]),
    .dd_valid_o(ddv[1]), .dd_data_o(ddd[1]), .dd_ready_i(ddr[1]));

  int total = 0, bad = 0, cyc = 0;
  int ren_cnt[2], rwe_cnt[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int s, input int x);
    return (s == 0) ? (16'(x * 40503) ^ 16'h1234) : (16'(x * 7919) ^ 16'h0F0F);
  endfunction

  // Synchronous-read RAMs; stored XOR pattern so the power-up content is pat().
  bit [15:0] ram_a [65536];
  bit [15:0] ram_b [4096];
  always @(posedge clk) begin
    if (ram_en[0]) begin
      if (ram_we[0]) ram_a[ra_a] <= ramwd[0] ^ pat(0, int'(ra_a));
      else           ramrd[0]    <= ram_a[ra_a] ^ pat(0, int'(ra_a));
    end
    if (ram_en[1]) begin
      if (ram_we[1]) ram_b[ra_b] <= ramwd[1] ^ pat(1, int'(ra_b));
      else           ramrd[1]    <= ram_b[ra_b] ^ pat(1, int'(ra_b));
    end
  end

  // Reference model state
  logic [15:0] exp_a [int];
  logic [15:0] exp_b [int];
  bit   [1:0]      mkb_full, mdd_pend;
  logic [1:0][7:0] mkb_buf, mdd_data;
  logic [16:0] q0[$], q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  task automatic mread(input int s, input logic [15:0] a, output logic [15:0] v);
    int k;
    v = '0;
    if (a[15:9] == 7'h7F) begin
      if (a == 16'hFE00) v = {mkb_full[s], 15'b0};
      else if (a == 16'hFE02) begin v = {8'h00, mkb_buf[s]}; mkb_full[s] = 1'b0; end
      else if (a == 16'hFE04) v = {~mdd_pend[s], 15'b0};
    end else begin
      k = (s == 0) ? int'(a) : int'(a) % 4096;
      if (s == 0) v = exp_a.exists(k) ? exp_a[k] : pat(0, k);
      else        v = exp_b.exists(k) ? exp_b[k] : pat(1, k);
    end
  endtask

  task automatic mwrite(input int s, input logic [15:0] a, input logic [15:0] d);
    if (a[15:9] == 7'h7F) begin
      if (a == 16'hFE06) begin mdd_pend[s] = 1'b1; mdd_data[s] = d[7:0]; end
    end else if (s == 0) exp_a[int'(a)] = d;
    else                 exp_b[int'(a) % 4096] = d;
  endtask

  // Single compare process: every ready pulse must match the next expected response.
  always @(negedge clk) begin
    logic [16:0] e;
    for (int s = 0; s < 2; s++) begin
      if (ram_en[s]) ren_cnt[s]++;
      if (ram_we[s]) rwe_cnt[s]++;
    end
    if (rdy[0]) begin
      if (q0.size() == 0) chk("unexpected_ready_a", 1, 0);
      else begin e = q0.pop_front(); if (e[16]) chk("rdata_a", rdata[0], e[15:0]); end
    end
    if (rdy[1]) begin
      if (q1.size() == 0) chk("unexpected_ready_b", 1, 0);
      else begin e = q1.pop_front(); if (e[16]) chk("rdata_b", rdata[1], e[15:0]); end
    end
  end

  task automatic txn(input int s, input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] rd);
    logic [15:0] v;
    logic [16:0] e;
    int t0, e0, w0;
    bit dv;
    dv = (a[15:9] == 7'h7F);
    if (!w) begin mread(s, a, v); e = {1'b1, v}; end
    else begin mwrite(s, a, d); e = 17'h0; end
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    en[s] = 1'b1; we[s] = w; addr[s] = a; wd[s] = d;
    t0 = cyc; e0 = ren_cnt[s]; w0 = rwe_cnt[s];
    lat = -1; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[s]) begin lat = cyc - t0 - 1; rd = rdata[s]; break; end
    end
    en[s] = 1'b0;
    chk("latency", 32'(lat), (s == 0) ? 32'd2 : 32'd5);
    chk("ram_en_count", 32'(ren_cnt[s] - e0), dv ? 32'd0 : 32'd1);
    chk("ram_we_count", 32'(rwe_cnt[s] - w0), (!dv && w) ? 32'd1 : 32'd0);
  endtask

  task automatic kb_beat(input logic [7:0] c);
    @(posedge clk); #1;
    kbv[0] = 1'b1; kbd[0] = c;
    if (!mkb_full[0]) begin mkb_full[0] = 1'b1; mkb_buf[0] = c; end
    @(posedge clk); #1;
    kbv[0] = 1'b0;
  endtask

  task automatic dd_accept();
    @(posedge clk); #1;
    ddr[0] = 1'b1; mdd_pend[0] = 1'b0;
    @(posedge clk); #1;
    ddr[0] = 1'b0;
  endtask

  function automatic logic [15:0] rnd_ram();
    if ($urandom_range(0, 1) == 1) return 16'h3000 + 16'($urandom_range(0, 15));
    return 16'($urandom) & 16'hFDFF;
  endfunction

  function automatic logic [15:0] rnd_dev();
    case ($urandom_range(0, 4))
      0: return 16'hFE00;
      1: return 16'hFE02;
      2: return 16'hFE04;
      3: return 16'hFE06;
      default: return 16'hFE00 | (16'($urandom) & 16'h01FF);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, t0, r, nr;
    int rt[3];
    int e0, w0;
    logic [15:0] rd, a;
    bit seen;
    rst = 2'b11; en = '0; we = '0; kbv = '0; ddr = '0; addr = '0; wd = '0; kbd = '0;
    mkb_full = '0; mdd_pend = '0; mkb_buf = '0; mdd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", rdy, 2'b00);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ram_en", ram_en, 2'b00);
    chk("reset_ram_we", ram_we, 2'b00);
    chk("reset_ram_addr", {ra_a, 4'h0, ra_b}, 32'h0);
    chk("reset_ram_wdata", ramwd, 32'h0);
    chk("reset_kb_ready", kbr, 2'b11);
    chk("reset_dd_valid", ddv, 2'b00);
    chk("reset_dd_data", ddd, 16'h0);
    @(posedge clk); #1; rst = 2'b00;

    // W=0 store/load
    txn(0, 1'b1, 16'h3000, 16'h1234, lat, rd);
    txn(0, 1'b0, 16'h3000, 16'h0000, lat, rd);
    chk("load_3000", rd, 16'h1234);

    // W=3 back-to-back loads with mem_en held
    for (int i = 0; i < 3; i++) begin mread(1, 16'h0123, rd); q1.push_back({1'b1, rd}); end
    @(posedge clk); #1;
    en[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0123; t0 = cyc; e0 = ren_cnt[1]; nr = 0;
    for (int i = 0; i < 40 && nr < 3; i++) begin
      @(negedge clk);
      if (rdy[1]) begin rt[nr] = cyc; nr++; if (nr == 3) en[1] = 1'b0; end
    end
    en[1] = 1'b0;
    chk("b2b_count", 32'(nr), 32'd3);
    chk("b2b_first_lat", 32'(rt[0] - t0 - 1), 32'd5);
    chk("b2b_interval1", 32'(rt[1] - rt[0]), 32'd6);
    chk("b2b_interval2", 32'(rt[2] - rt[1]), 32'd6);
    repeat (3) @(negedge clk);
    chk("b2b_ram_en", 32'(ren_cnt[1] - e0), 32'd3);

    // Keyboard
    kb_beat(8'h41);
    @(negedge clk);
    chk("kb_ready_full", kbr[0], 1'b0);
    txn(0, 1'b0, 16'hFE00, 16'h0, lat, rd); chk("kbsr_full", rd, 16'h8000);
    txn(0, 1'b0, 16'hFE02, 16'h0, lat, rd); chk("kbdr", rd, 16'h0041);
    txn(0, 1'b0, 16'hFE00, 16'h0, lat, rd); chk("kbsr_empty", rd, 16'h0000);
    chk("kb_ready_empty", kbr[0], 1'b1);

    // Display with stall
    txn(0, 1'b1, 16'hFE06, 16'h0048, lat, rd);
    chk("dd_valid_1", ddv[0], 1'b1);
    chk("dd_data_1", ddd[0], 8'h48);
    txn(0, 1'b0, 16'hFE04, 16'h0, lat, rd); chk("dsr_busy", rd, 16'h0000);
    q0.push_back(17'h0);
    @(posedge clk); #1;
    en[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'hFE06; wd[0] = 16'h0055;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rdy[0]) seen = 1'b1; end
    chk("ddr_stall_no_ready", seen, 1'b0);
    chk("ddr_stall_data_held", ddd[0], 8'h48);
    @(posedge clk); #1; ddr[0] = 1'b1; t0 = cyc;
    @(posedge clk); #1; ddr[0] = 1'b0;
    r = -1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rdy[0]) begin r = cyc; break; end end
    en[0] = 1'b0;
    chk("ddr_release_lat", 32'(r - t0), 32'd3);
    chk("dd_data_2", ddd[0], 8'h55);
    chk("dd_valid_2", ddv[0], 1'b1);
    mdd_pend[0] = 1'b1; mdd_data[0] = 8'h55;
    dd_accept();
    @(negedge clk);
    chk("dd_valid_cleared", ddv[0], 1'b0);

    // Reset during WAIT of a store on DUT B
    w0 = rwe_cnt[1];
    @(posedge clk); #1;
    en[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0010; wd[1] = 16'hBEEF;
    @(posedge clk); #1;
    rst[1] = 1'b1; en[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rdy[1]) seen = 1'b1; end
    chk("rst_abort_no_ready", seen, 1'b0);
    chk("rst_abort_no_we", 32'(rwe_cnt[1] - w0), 32'd0);
    txn(1, 1'b0, 16'h0010, 16'h0, lat, rd);
    chk("rst_abort_pretest", rd, pat(1, 16));

    // Aliasing on ADDR_W=12
    txn(1, 1'b1, 16'h1005, 16'hC0DE, lat, rd);
    txn(1, 1'b0, 16'h0005, 16'h0, lat, rd);
    chk("alias_load", rd, 16'hC0DE);
    txn(1, 1'b0, 16'hFE10, 16'h0, lat, rd);
    chk("dev_other_zero", rd, 16'h0000);

    // Randomized traffic on DUT A
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: txn(0, 1'b1, rnd_ram(), 16'($urandom), lat, rd);
        3, 4:    txn(0, 1'b0, rnd_ram(), 16'h0, lat, rd);
        5:       txn(0, 1'b0, rnd_dev(), 16'h0, lat, rd);
        6: begin
          if ($urandom_range(0, 1) == 1) kb_beat(8'($urandom));
          else if (!mdd_pend[0]) txn(0, 1'b1, 16'hFE06, 16'($urandom), lat, rd);
          else dd_accept();
        end
        default: begin
          a = rnd_dev();
          if (a == 16'hFE06) a = 16'hFE02;
          txn(0, 1'b1, a, 16'($urandom), lat, rd);
        end
      endcase
      chk("rnd_kb_ready", kbr[0], !mkb_full[0]);
      chk("rnd_dd_valid", ddv[0], mdd_pend[0]);
      if (mdd_pend[0]) chk("rnd_dd_data", ddd[0], mdd_data[0]);
    end

    // Randomized RAM traffic on DUT B
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) txn(1, 1'b1, rnd_ram(), 16'($urandom), lat, rd);
      else                           txn(1, 1'b0, rnd_ram(), 16'h0, lat, rd);
    end

    repeat (4) @(negedge clk);
    chk("queue_a_drained", 32'(q0.size()), 32'd0);
    chk("queue_b_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
